// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and game-key decoder.
// Arrow keys drive level outputs; Enter and Esc give single-cycle press pulses.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       enter,
  output logic       pause,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic [1:0]    ck_s_q, dt_s_q;
  logic          ck_prev_q;
  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          ent_pr_q, ent_pr_d, esc_pr_q, esc_pr_d;
  logic          up_q, up_d, down_q, down_d;
  logic          left_q, left_d, right_q, right_d;
  logic          enter_q, enter_d, pause_q, pause_d;
  logic          cv_q, cv_d, err_q, err_d;
  logic [7:0]    code_q, code_d;

  logic fall, bit_in, timeout;
  logic byte_ok, byte_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_s_q    <= 2'b11;
      dt_s_q    <= 2'b11;
      ck_prev_q <= 1'b1;
    end else begin
      ck_s_q    <= {ck_s_q[0], ps2_clk};
      dt_s_q    <= {dt_s_q[0], ps2_data};
      ck_prev_q <= ck_s_q[1];
    end
  end

  assign fall    = ck_prev_q & ~ck_s_q[1];
  assign bit_in  = dt_s_q[1];
  assign timeout = (state_q != IDLE) && !fall && (to_q == TO_MAX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    to_d     = to_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    ent_pr_d = ent_pr_q;
    esc_pr_d = esc_pr_q;
    up_d     = up_q;
    down_d   = down_q;
    left_d   = left_q;
    right_d  = right_q;
    enter_d  = 1'b0;
    pause_d  = 1'b0;
    cv_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;

    if (state_q == IDLE || fall) begin
      to_d = '0;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + 1'b1;
    end

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d = DATA;
            cnt_d   = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d = {bit_in, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = bit_in;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (bit_in && (^{shift_q, par_q})) byte_ok = 1'b1;
          else byte_bad = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end

    if (byte_bad) begin
      err_d = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end

    if (byte_ok) begin
      cv_d   = 1'b1;
      code_d = shift_q;
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        // Keypad arrows (no E0 prefix) match no arm and fall through.
        unique case (1'b1)
          ext_q && shift_q == 8'h75: up_d    = ~brk_q;
          ext_q && shift_q == 8'h72: down_d  = ~brk_q;
          ext_q && shift_q == 8'h6B: left_d  = ~brk_q;
          ext_q && shift_q == 8'h74: right_d = ~brk_q;
          shift_q == 8'h5A: begin
            if (brk_q) begin
              ent_pr_d = 1'b0;
            end else if (!ent_pr_q) begin
              enter_d  = 1'b1;
              ent_pr_d = 1'b1;
            end
          end
          !ext_q && shift_q == 8'h76: begin
            if (brk_q) begin
              esc_pr_d = 1'b0;
            end else if (!esc_pr_q) begin
              pause_d  = 1'b1;
              esc_pr_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      to_q     <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      ent_pr_q <= 1'b0;
      esc_pr_q <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      enter_q  <= 1'b0;
      pause_q  <= 1'b0;
      cv_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      to_q     <= to_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      ent_pr_q <= ent_pr_d;
      esc_pr_q <= esc_pr_d;
      up_q     <= up_d;
      down_q   <= down_d;
      left_q   <= left_d;
      right_q  <= right_d;
      enter_q  <= enter_d;
      pause_q  <= pause_d;
      cv_q     <= cv_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign up         = up_q;
  assign down       = down_q;
  assign left       = left_q;
  assign right      = right_q;
  assign enter      = enter_q;
  assign pause      = pause_q;
  assign code_valid = cv_q;
  assign code       = code_q;
  assign frame_err  = err_q;

endmodule
